aes_inv_top: RTL and testbench

- Iterative AES-128 decryption core; the inverse of the existing AES_top encryption block, with the same port contract.
- Accepts 128-bit ciphertext and the 128-bit cipher key, expands the key forward to round key 10, then runs 10 inverse rounds, one per clock, regenerating each round key backwards on the fly.
- Sits beside AES_top so the encrypt/decrypt pair is verified end to end: AES_top output feeds aes_inv_top input and must return the original plaintext.

---
 rtl/aes_pkg.sv | 101 ++++++++++
 rtl/aes_key_step.sv | 29 ++
 rtl/aes_inv_top.sv | 113 +++++++++++
 tb/tb_aes_inv_top.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 constants and GF(2^8) helpers shared by the inverse cipher core.
// Byte 0 of a 128-bit block sits in bits [127:120]; bytes fill columns first.
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, DONE} aes_state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8 * i +: 8] = INV_SBOX[s[8 * i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
      o[127 - 32 * c -: 32] = {
        gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
        gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
        gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
        gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (dir_i=0) or backward (dir_i=1).
// Both directions share a single 4-byte S-box lookup.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  input  logic         dir_i,
  output logic [127:0] rk_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw_in, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_i;

  // Going backward, the S-box must see the previous key's last word, which is w3^w2.
  assign sw_in = dir_i ? (w3 ^ w2) : w3;
  assign t     = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rcon_i, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_o = dir_i ? {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2} : {n0, n1, n2, n3};

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryption: forward key expansion to round key 10, then
// ten inverse rounds at one per clock with the round key rolled back on the fly.
module aes_inv_top
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  aes_state_e   state_q, state_d;
  logic         en_q;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] out_q, out_d;
  logic         valid_q, valid_d;

  logic         start;
  logic         key_dir;
  logic [3:0]   rcon_idx;
  logic [7:0]   rcon;
  logic [127:0] rk_step;
  logic [127:0] t_round;

  assign start   = (state_q == IDLE) && AES_en && !en_q;
  assign key_dir = (state_q != KEYEXP);

  // cnt_q holds 9 on leaving KEYEXP, so ADDKEY reuses it to pick rcon[9].
  assign rcon_idx = (state_q == ROUND) ? cnt_q - 4'd1 : cnt_q;
  assign rcon     = (rcon_idx < 4'd10) ? RCON[rcon_idx] : 8'h00;

  aes_key_step u_key_step (
    .rk_i   (rk_q),
    .rcon_i (rcon),
    .dir_i  (key_dir),
    .rk_o   (rk_step)
  );

  assign t_round = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_q;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = AES_data_in;
          rk_d    = AES_key_in;
          cnt_d   = 4'd0;
          state_d = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_d = rk_step;
        if (cnt_q == 4'(NR - 1)) state_d = ADDKEY;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      ADDKEY: begin
        st_d    = st_q ^ rk_q;
        rk_d    = rk_step;
        state_d = ROUND;
      end
      ROUND: begin
        if (cnt_q != 4'd0) begin
          st_d  = inv_mix_columns(t_round);
          rk_d  = rk_step;
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_d   = t_round;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      st_q    <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= AES_en;
      st_q    <= st_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign AES_data_out       = out_q;
  assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_inv_top.sv
// Directed and loopback checks for the iterative AES-128 decryption core.
module tb_aes_inv_top;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] kin = '0;
  logic [127:0] dout;
  logic         dvalid;

  always #5 clk = ~clk;

  aes_inv_top #(.NR(10)) dut (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .AES_en             (en),
    .AES_data_in        (din),
    .AES_key_in         (kin),
    .AES_data_out       (dout),
    .AES_data_out_valid (dvalid)
  );

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [3];
  int total = 0;
  int bad = 0;

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One-cycle en pulse; returns the result and the cycle of the valid pulse (0 = timeout).
  task automatic run_op(input logic [127:0] key, input logic [127:0] data,
                        output logic [127:0] res, output int lat);
    @(negedge clk);
    kin = key; din = data; en = 1'b1;
    lat = 0; res = '0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      if (dvalid) begin lat = c; res = dout; end
    end
  endtask

  // Independent forward-cipher reference used for loopback vectors.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k, u;
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    s = pt ^ key; k = key; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t = {k[23:0], k[31:24]};
      t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
      rc = xt(rc);
      k[127:96] = k[127:96] ^ t;
      k[95:64]  = k[95:64] ^ k[127:96];
      k[63:32]  = k[63:32] ^ k[95:64];
      k[31:0]   = k[31:0] ^ k[63:32];
      for (int i = 0; i < 16; i++) s[8 * i +: 8] = SBOX[s[8 * i +: 8]];
      u = s;
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[127 - 8 * (rr + 4 * c) -: 8] = u[127 - 8 * (rr + 4 * ((c + rr) % 4)) -: 8];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
          s[127 - 32 * c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = s ^ k;
    end
    return s;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] res, res2, pt, key;
    int lat, pulses, seen;

    vecs[0] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{"fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{"zero_key", 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk128("reset_out", dout, 128'h0);
    chk_int("reset_valid", int'(dvalid), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_op(vecs[i].key, vecs[i].data, res, lat);
      chk128({vecs[i].name, "_out"}, res, vecs[i].exp);
      chk_int({vecs[i].name, "_latency"}, lat, 22);
      @(negedge clk);
      chk_int({vecs[i].name, "_pulse_width"}, int'(dvalid), 0);
      $display("vec %s: out=%h lat=%0d", vecs[i].name, res, lat);
    end

    // Round key 10 as seen on entry to ADDKEY.
    @(negedge clk);
    kin = vecs[1].key; din = vecs[1].data; en = 1'b1;
    seen = 0;
    for (int c = 1; c <= 30 && seen == 0; c++) begin
      @(negedge clk);
      en = 1'b0;
      if (dut.state_q == ADDKEY) seen = c;
    end
    chk_int("addkey_reached", seen, 11);
    chk128("addkey_rk", dut.rk_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (15) @(negedge clk);
    $display("seq addkey_rk: rk=%h at cycle %0d", dut.rk_q, seen);

    // en held high for 51 cycles while inputs change.
    @(negedge clk);
    kin = vecs[0].key; din = vecs[0].data; en = 1'b1;
    pulses = 0; res = '0;
    for (int c = 1; c <= 51; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 3)  begin din = 128'hdeadbeef; kin = 128'h1234; end
      if (c == 25) din = vecs[1].data;
      if (dvalid) begin pulses++; res = dout; end
    end
    en = 1'b0;
    chk_int("hold_en_pulses", pulses, 1);
    chk128("hold_en_out", res, vecs[0].exp);
    $display("seq hold_en: pulses=%0d out=%h", pulses, res);

    // Reset during the key/round pipeline.
    @(negedge clk);
    kin = vecs[1].key; din = vecs[1].data; en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk128("midrst_out_now", dout, 128'h0);
    chk_int("midrst_valid_now", int'(dvalid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (dvalid) pulses++;
    end
    chk_int("midrst_pulses", pulses, 0);
    chk128("midrst_out_after", dout, 128'h0);
    run_op(vecs[0].key, vecs[0].data, res, lat);
    chk128("midrst_restart_out", res, vecs[0].exp);
    chk_int("midrst_restart_latency", lat, 22);
    $display("seq midrst: restart out=%h lat=%0d", res, lat);

    // Back-to-back starts 23 cycles apart, plus an ignored mid-operation pulse.
    @(negedge clk);
    kin = vecs[0].key; din = vecs[0].data; en = 1'b1;
    pulses = 0; res = '0; res2 = '0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      if (c == 23) begin kin = vecs[1].key; din = vecs[1].data; en = 1'b1; end
      if (c == 33) begin kin = 128'h0; din = 128'h5555; en = 1'b1; end
      if (dvalid) begin
        pulses++;
        if (pulses == 1) res = dout; else res2 = dout;
        if (pulses == 2) chk_int("b2b_second_cycle", c, 45);
      end
    end
    chk_int("b2b_pulses", pulses, 2);
    chk128("b2b_first_out", res, vecs[0].exp);
    chk128("b2b_second_out", res2, vecs[1].exp);
    $display("seq b2b: pulses=%0d out1=%h out2=%h", pulses, res, res2);

    // Loopback through the reference forward cipher.
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      run_op(key, enc(pt, key), res, lat);
      chk128("loopback", res, pt);
      $display("loop %0d: key=%h pt=%h out=%h", i, key, pt, res);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
